// File: rtl/timer_bank.sv
// Bus-programmable timer: prescaled free-running counter, coherent 64-bit
// snapshot reads, and CHANNELS compare registers driving level interrupts.
module timer_bank #(
  parameter int WIDTH      = 64,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [7:0]          addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                ack_o,
  output logic [WIDTH-1:0]    count_o,
  output logic [CHANNELS-1:0] irq_o
);

  localparam logic [7:0] A_CTRL     = 8'h00;
  localparam logic [7:0] A_PRESCALE = 8'h01;
  localparam logic [7:0] A_COUNT_LO = 8'h02;
  localparam logic [7:0] A_COUNT_HI = 8'h03;

  logic                  en;
  logic [CHANNELS-1:0]   ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [WIDTH-1:0]      count;
  logic [31:0]           shadow;
  logic [WIDTH-1:0]      cmp [CHANNELS];
  logic [CHANNELS-1:0]   irq_p1;
  logic                  vld_p1;
  logic [31:0]           rdata_p1;

  logic                  wr;
  logic                  rd;
  logic                  tick;
  logic                  count_wr_en;
  logic [63:0]           count_ext;
  logic [63:0]           count_wr;
  logic [63:0]           cmp_ext [CHANNELS];
  logic [31:0]           rd_data;

  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign tick        = en && (pre_cnt == prescale);
  assign count_wr_en = wr && ((addr_i == A_COUNT_LO) || (addr_i == A_COUNT_HI));

  // Zero-extended 64-bit views keep the half-word muxing uniform for any WIDTH.
  always_comb begin
    count_ext = 64'(count);
    count_wr  = count_ext;
    if (addr_i == A_COUNT_LO) count_wr[31:0]  = wdata_i;
    if (addr_i == A_COUNT_HI) count_wr[63:32] = wdata_i;
    for (int i = 0; i < CHANNELS; i++) cmp_ext[i] = 64'(cmp[i]);
  end

  always_comb begin
    rd_data = '0;
    case (addr_i)
      A_CTRL: begin
        rd_data[0]             = en;
        rd_data[8 +: CHANNELS] = ie;
      end
      A_PRESCALE: rd_data = 32'(prescale);
      A_COUNT_LO: rd_data = count_ext[31:0];
      A_COUNT_HI: rd_data = shadow;
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (addr_i == 8'(4 + 2 * i)) rd_data = cmp_ext[i][31:0];
          if (addr_i == 8'(5 + 2 * i)) rd_data = cmp_ext[i][63:32];
        end
      end
    endcase
  end

  // Stage p1: register state update, bus response and interrupt levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en       <= 1'b0;
      ie       <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      count    <= '0;
      shadow   <= '0;
      irq_p1   <= '0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      for (int i = 0; i < CHANNELS; i++) cmp[i] <= '1;
    end else begin
      vld_p1   <= req_i;
      rdata_p1 <= rd ? rd_data : '0;

      if (wr && addr_i == A_CTRL) begin
        en <= wdata_i[0];
        ie <= wdata_i[8 +: CHANNELS];
      end
      if (wr && addr_i == A_PRESCALE) prescale <= PRESCALE_W'(wdata_i);

      if ((wr && addr_i == A_PRESCALE) || !en || tick) pre_cnt <= '0;
      else                                              pre_cnt <= pre_cnt + PRESCALE_W'(1);

      // A software write beats a coincident tick; that increment is lost.
      if (count_wr_en) count <= WIDTH'(count_wr);
      else if (tick)   count <= count + WIDTH'(1);

      if (rd && addr_i == A_COUNT_LO) shadow <= count_ext[63:32];

      for (int i = 0; i < CHANNELS; i++) begin
        if (wr && addr_i == 8'(4 + 2 * i)) cmp[i] <= WIDTH'({cmp_ext[i][63:32], wdata_i});
        if (wr && addr_i == 8'(5 + 2 * i)) cmp[i] <= WIDTH'({wdata_i, cmp_ext[i][31:0]});
        irq_p1[i] <= ie[i] & (count >= cmp[i]);
      end
    end
  end

  assign ack_o   = vld_p1;
  assign rdata_o = rdata_p1;
  assign count_o = count;
  assign irq_o   = irq_p1;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank (WIDTH=64, CHANNELS=2, PRESCALE_W=16).
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [63:0] count_o;
  logic [1:0]  irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp;

  timer_bank #(.WIDTH(64), .CHANNELS(2), .PRESCALE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .count_o(count_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Drive a write across one rising edge; returns at the following negedge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  // Drive a read and queue its expected data; response is visible on return.
  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    sb_q.push_back(e);
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (count_o !== 64'd0 || irq_o !== 2'b00 || ack_o !== 1'b0 || rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got count=%h irq=%b ack=%b rdata=%h exp all zero",
               count_o, irq_o, ack_o, rdata_o);
    end
    rst_n = 1'b1;
    rd(8'h04, 32'hFFFF_FFFF);
    exp = sb_q.pop_front(); checks++;
    if (ack_o !== 1'b1 || rdata_o !== exp) begin
      errors++; $display("FAIL reset_cmp0_lo got ack=%b rdata=%h exp %h", ack_o, rdata_o, exp);
    end
    rd(8'h07, 32'hFFFF_FFFF);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL reset_cmp1_hi got %h exp %h", rdata_o, exp);
    end
  endtask

  task automatic test_free_run;
    wr(8'h00, 32'h1);
    repeat (10) @(negedge clk);
    checks++;
    if (count_o !== 64'd10 || irq_o !== 2'b00) begin
      errors++; $display("FAIL free_run got count=%0d irq=%b exp 10/00", count_o, irq_o);
    end
  endtask

  task automatic test_prescale;
    wr(8'h00, 32'h0); wr(8'h02, 32'h0); wr(8'h03, 32'h0); wr(8'h01, 32'h3);
    wr(8'h00, 32'h1);
    repeat (19) @(negedge clk);
    checks++;
    if (count_o !== 64'd4) begin
      errors++; $display("FAIL prescale_19 got %0d exp 4", count_o);
    end
    wr(8'h00, 32'h0);
    checks++;
    if (count_o !== 64'd5) begin
      errors++; $display("FAIL prescale_20 got %0d exp 5", count_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (count_o !== 64'd5) begin
      errors++; $display("FAIL prescale_hold got %0d exp 5", count_o);
    end
    wr(8'h00, 32'h1);
    repeat (3) @(negedge clk);
    checks++;
    if (count_o !== 64'd5) begin
      errors++; $display("FAIL prescale_reen_early got %0d exp 5", count_o);
    end
    @(negedge clk);
    checks++;
    if (count_o !== 64'd6) begin
      errors++; $display("FAIL prescale_reen_tick got %0d exp 6", count_o);
    end
  endtask

  task automatic test_snapshot;
    wr(8'h00, 32'h0); wr(8'h01, 32'h0);
    wr(8'h02, 32'hFFFF_FFFF); wr(8'h03, 32'h0);
    wr(8'h00, 32'h1);
    rd(8'h02, 32'hFFFF_FFFF);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL snap_lo got %h exp %h", rdata_o, exp);
    end
    rd(8'h03, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL snap_hi_coherent got %h exp %h", rdata_o, exp);
    end
    checks++;
    if (count_o !== 64'h1_0000_0001) begin
      errors++; $display("FAIL carry got %h exp 100000001", count_o);
    end
    rd(8'h03, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL snap_hi_stale got %h exp %h", rdata_o, exp);
    end
    rd(8'h02, 32'h2);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL snap_lo2 got %h exp %h", rdata_o, exp);
    end
    rd(8'h03, 32'h1);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL snap_hi2 got %h exp %h", rdata_o, exp);
    end
  endtask

  task automatic test_wrap;
    wr(8'h00, 32'h0); wr(8'h02, 32'hFFFF_FFFE); wr(8'h03, 32'hFFFF_FFFF);
    wr(8'h00, 32'h1);
    @(negedge clk);
    checks++;
    if (count_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL wrap_max got %h exp all ones", count_o);
    end
    @(negedge clk);
    checks++;
    if (count_o !== 64'd0 || irq_o !== 2'b00) begin
      errors++; $display("FAIL wrap_zero got count=%h irq=%b exp 0/00", count_o, irq_o);
    end
  endtask

  task automatic test_compare;
    wr(8'h00, 32'h0); wr(8'h02, 32'h0); wr(8'h03, 32'h0);
    wr(8'h04, 32'd100); wr(8'h05, 32'h0); wr(8'h06, 32'd50); wr(8'h07, 32'h0);
    wr(8'h00, 32'h101);
    repeat (99) @(negedge clk);
    checks++;
    if (count_o !== 64'd99 || irq_o !== 2'b00) begin
      errors++; $display("FAIL cmp_before got count=%0d irq=%b exp 99/00", count_o, irq_o);
    end
    @(negedge clk);
    checks++;
    if (count_o !== 64'd100 || irq_o !== 2'b00) begin
      errors++; $display("FAIL cmp_equal got count=%0d irq=%b exp 100/00", count_o, irq_o);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 2'b01) begin
      errors++; $display("FAIL cmp_rise got irq=%b exp 01", irq_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (irq_o !== 2'b01) begin
      errors++; $display("FAIL cmp_level got irq=%b exp 01", irq_o);
    end
    wr(8'h04, 32'd200);
    checks++;
    if (irq_o !== 2'b01) begin
      errors++; $display("FAIL cmp_raise_n1 got irq=%b exp 01", irq_o);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 2'b00) begin
      errors++; $display("FAIL cmp_raise_n2 got irq=%b exp 00", irq_o);
    end
    rd(8'h04, 32'd200);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL cmp_readback got %h exp %h", rdata_o, exp);
    end
  endtask

  task automatic test_back_to_back;
    wr(8'h00, 32'h0); wr(8'h03, 32'h0); wr(8'h02, 32'h0);
    wr(8'h00, 32'h1);
    wr(8'h02, 32'h1234);
    checks++;
    if (count_o !== 64'h1234) begin
      errors++; $display("FAIL write_vs_tick got %h exp 1234", count_o);
    end
    rd(8'h02, 32'h1234);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp || count_o !== 64'h1235) begin
      errors++; $display("FAIL post_write_read got rdata=%h count=%h exp %h/1235", rdata_o, count_o, exp);
    end
    wr(8'h01, 32'h7);
    rd(8'h01, 32'h7);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL raw_prescale got %h exp %h", rdata_o, exp);
    end
    wr(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, 32'h0000_0301);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL raw_ctrl got %h exp %h", rdata_o, exp);
    end
    rd(8'hFF, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (ack_o !== 1'b1 || rdata_o !== exp) begin
      errors++; $display("FAIL unmapped_ff got ack=%b rdata=%h exp 1/%h", ack_o, rdata_o, exp);
    end
    wr(8'hFF, 32'hDEAD_BEEF);
    checks++;
    if (ack_o !== 1'b1 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL unmapped_wr got ack=%b rdata=%h exp 1/0", ack_o, rdata_o);
    end
    rd(8'h08, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL unmapped_08 got %h exp %h", rdata_o, exp);
    end
  endtask

  task automatic test_reset_mid;
    checks++;
    if (irq_o !== 2'b11) begin
      errors++; $display("FAIL pre_reset_irq got %b exp 11", irq_o);
    end
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h02;
    @(negedge clk);
    checks++;
    if (ack_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_ack got %b exp 1", ack_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_o !== 1'b0 || rdata_o !== 32'h0 || count_o !== 64'd0 || irq_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort got ack=%b rdata=%h count=%h irq=%b exp 0/0/0/00",
               ack_o, rdata_o, count_o, irq_o);
    end
    rst_n = 1'b1; req_i = 1'b0;
    rd(8'h00, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL reset_ctrl got %h exp %h", rdata_o, exp);
    end
    rd(8'h01, 32'h0);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL reset_prescale got %h exp %h", rdata_o, exp);
    end
    rd(8'h04, 32'hFFFF_FFFF);
    exp = sb_q.pop_front(); checks++;
    if (rdata_o !== exp) begin
      errors++; $display("FAIL reset_cmp0 got %h exp %h", rdata_o, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_free_run();
    test_prescale();
    test_snapshot();
    test_wrap();
    test_compare();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised, bus-programmable timer block for the controller. It holds one free-running up-counter of configurable width behind a programmable prescaler, plus CHANNELS compare registers that each drive a level interrupt. A 32-bit single-cycle register port sits beside the existing memory-mapped peripherals, and a snapshot register makes 64-bit reads coherent. `count_o` still exposes the full counter for direct in-fabric use.

## Interface
- `WIDTH`, 64, counter and compare width; legal 32..64.
- `CHANNELS`, 2, number of compare/interrupt channels; legal 1..8.
- `PRESCALE_W`, 16, prescaler register width; legal 1..32.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk.
- `req_i`  in  1  bus request, one per cycle, back-to-back allowed.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  8  word address.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, valid with `ack_o`; 0 otherwise.
- `ack_o`  out  1  pulses one cycle after every accepted `req_i`.
- `count_o`  out  WIDTH  live counter value.
- `irq_o`  out  CHANNELS  per-channel level interrupt.

## Operation
- Register map (word addresses):
  - 0x00 CTRL: bit0 = EN; bits [8+CHANNELS-1:8] = IE per channel; other bits read 0.
  - 0x01 PRESCALE.
  - 0x02 COUNT_LO.
  - 0x03 COUNT_HI.
  - 0x04+2i CMP_LO of channel i.
  - 0x05+2i CMP_HI of channel i.
- Unmapped addresses read 0, ignore writes, and are still acked.
- Bits at or above WIDTH read 0 and ignore writes. When WIDTH = 32, COUNT_HI and CMP_HI read 0.
- Prescaler:
  - Internal `pre_cnt` of PRESCALE_W bits.
  - When EN = 1: if `pre_cnt` == PRESCALE, a tick occurs and `pre_cnt` returns to 0; otherwise `pre_cnt` increments.
  - A tick therefore occurs every PRESCALE+1 cycles; PRESCALE = 0 ticks every cycle.
  - EN = 0 holds the counter and forces `pre_cnt` to 0.
  - A write to PRESCALE clears `pre_cnt`.
- Counter:
  - Increments by 1 per tick.
  - Wraps from 2^WIDTH-1 to 0 with no flag.
- Counter writes:
  - A write to COUNT_LO or COUNT_HI replaces that half only.
  - If a tick falls in the same cycle, the write wins and the increment is dropped. `pre_cnt` is unaffected.
- Snapshot:
  - A read of COUNT_LO returns count[31:0] and, on the same edge, latches count[WIDTH-1:32] into a shadow register.
  - A read of COUNT_HI returns the shadow, not the live value.
  - Software reads LO then HI for a coherent 64-bit value.
- Compare:
  - `irq_o[i]` is registered: next value = IE[i] & (count >= CMP[i]), unsigned compare on WIDTH bits, using current register values.
  - Software clears an interrupt by raising CMP or clearing IE.
  - CMP halves are written independently. Software disables IE while updating both halves.

## Timing
- Reset values:
  - count = 0, `pre_cnt` = 0, shadow = 0.
  - CTRL = 0, PRESCALE = 0.
  - all CMP = all-ones.
  - `irq_o` = 0, `ack_o` = 0, `rdata_o` = 0, `count_o` = 0.
- Reset mid-transaction aborts it: no `ack_o` the next cycle.
- Bus timing:
  - A request is sampled at edge N.
  - `ack_o` and `rdata_o` are valid in cycle N+1.
  - Read data reflects register state before edge N's updates, so a COUNT_LO read shows the value prior to that edge's increment.
- Write timing:
  - A write sampled at edge N takes effect at edge N.
  - `count_o` shows the new value from cycle N+1.
  - `irq_o` reflects it from cycle N+2.
- Read-after-write to the same address back-to-back returns the new value.
- First tick after EN goes 1 at edge N lands at edge N+PRESCALE+1.
- Interrupt latency: count reaches CMP at edge M; `irq_o` rises at edge M+1.

## Test plan
- Reset release, EN=1, PRESCALE=0, 10 cycles -> `count_o` = 10. `irq_o` = 0 with CMP = all-ones.
- PRESCALE=3, EN=1 for 20 cycles -> `count_o` = 5. Clear EN -> count holds at 5. Set EN again -> next tick after 4 cycles.
- Write COUNT_LO = 0xFFFFFFFF and COUNT_HI = 0x0, free-run -> carry reaches count[32]. Read LO then HI -> the pair is coherent. Issue HI before LO -> HI returns the stale shadow.
- WIDTH=64, count = 2^64-2, PRESCALE=0 -> wraps to 0 two ticks later with no flag.
- CMP0 = 100, IE0 = 1, count from 0 -> `irq_o[0]` rises one cycle after count = 100 and stays high. Write CMP0_LO = 200 -> `irq_o[0]` falls 2 cycles later. Channel 1 with IE1 = 0 stays low throughout.
- Back-to-back requests:
  - COUNT_LO write coinciding with a tick -> the written value is kept and the increment is dropped.
  - Unmapped address 0xFF read -> acked with 0.
  - Reset asserted the cycle after a request -> no ack and all outputs return to reset values.
